// File: rtl/pipe_commit_tracker_if.sv
// pipe_commit_tracker_if: stimulus and observation bundle for the commit tracker
// PIPE_TOKEN_LOST_CHK_EN adds the tok_lost/dup_tok observation signals
interface pipe_commit_tracker_if #(
    parameter int NUM_PIPES  = 2,
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 8
);
    logic                            issue;
    logic [NUM_PIPES-1:0]            inj_gate;
    logic [NUM_PIPES*NUM_STAGES-1:0] stall;
    logic [NUM_PIPES-1:0]            end_sel;
    logic                            start;
    logic                            started;
    logic [CNT_W-1:0]                cycle_cnt;
    logic [NUM_PIPES*NUM_STAGES-1:0] stage_tok;
    logic [NUM_PIPES-1:0]            commit;
    logic                            ended;
    logic                            end2_pulse;
    logic                            ended2;
    logic                            timeout;
`ifdef PIPE_TOKEN_LOST_CHK_EN
    logic [NUM_PIPES-1:0]            tok_lost;
    logic                            dup_tok;
    modport master (
        output issue, inj_gate, stall, end_sel,
        input  start, started, cycle_cnt, stage_tok, commit, ended, end2_pulse, ended2, timeout,
               tok_lost, dup_tok
    );
    modport slave (
        input  issue, inj_gate, stall, end_sel,
        output start, started, cycle_cnt, stage_tok, commit, ended, end2_pulse, ended2, timeout,
               tok_lost, dup_tok
    );
`else
    modport master (
        output issue, inj_gate, stall, end_sel,
        input  start, started, cycle_cnt, stage_tok, commit, ended, end2_pulse, ended2, timeout
    );
    modport slave (
        input  issue, inj_gate, stall, end_sel,
        output start, started, cycle_cnt, stage_tok, commit, ended, end2_pulse, ended2, timeout
    );
`endif
endinterface

// File: rtl/pipe_commit_tracker.sv
// pipe_commit_tracker: follows one token through NUM_PIPES stall-aware pipes, reports commit/end/timeout
// PIPE_TOKEN_LOST_CHK_EN adds sticky tok_lost/dup_tok flags
module pipe_commit_tracker #(
    parameter int NUM_PIPES  = 2,
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 8,
    parameter int CNT_SAT    = 132,
    parameter int END_BOUND  = 50
) (
    input logic                 clk,
    input logic                 rst_n,
    pipe_commit_tracker_if.slave bus
);
    localparam int NS = NUM_STAGES;
    localparam int L  = NUM_STAGES - 1;
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(CNT_SAT);
    localparam logic [CNT_W-1:0] BOUND = CNT_W'(END_BOUND);
    logic [NUM_PIPES*NS-1:0] tok, adv;
    logic [NUM_PIPES*L-1:0]  tok_q, tok_d;
    logic [NUM_PIPES-1:0]    commit_d;
    logic                    end_cond;
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_p
        assign tok[p*NS] = bus.start & bus.inj_gate[p];
        assign tok[p*NS+1 +: L] = tok_q[p*L +: L];
        // a stalled stage keeps its content, so a token arriving from upstream is dropped
        assign tok_d[p*L +: L] = (bus.stall[p*NS+1 +: L] & tok_q[p*L +: L])
                               | (~bus.stall[p*NS+1 +: L] & adv[p*NS +: L]);
        assign commit_d[p] = adv[p*NS+NS-1];
    end
    assign adv = tok & ~bus.stall;
    assign bus.stage_tok = tok;
    assign end_cond = |(bus.commit & bus.end_sel) & bus.started;
    assign bus.end2_pulse = bus.ended & end_cond & ~bus.ended2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.start     <= 1'b0;
            bus.started   <= 1'b0;
            bus.cycle_cnt <= '0;
            tok_q         <= '0;
            bus.commit    <= '0;
            bus.ended     <= 1'b0;
            bus.ended2    <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.start   <= ~(bus.start | bus.started) & bus.issue;
            bus.started <= bus.started | bus.start;
            if ((bus.start | bus.started) && bus.cycle_cnt < SAT)
                bus.cycle_cnt <= bus.cycle_cnt + CNT_W'(1);
            tok_q       <= tok_d;
            bus.commit  <= commit_d;
            bus.ended   <= bus.ended | (end_cond & (bus.cycle_cnt <= BOUND));
            bus.ended2  <= bus.ended2 | bus.end2_pulse;
            bus.timeout <= bus.timeout | (bus.started & ~bus.ended & (bus.cycle_cnt > BOUND));
        end
    end
`ifdef PIPE_TOKEN_LOST_CHK_EN
    logic [NUM_PIPES-1:0] lost, dup;
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_chk
        assign lost[p] = |(adv[p*NS +: L] & bus.stall[p*NS+1 +: L]);
        assign dup[p]  = |(tok[p*NS +: NS] & (tok[p*NS +: NS] - NS'(1)));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tok_lost <= '0;
            bus.dup_tok  <= 1'b0;
        end else begin
            bus.tok_lost <= bus.tok_lost | lost;
            bus.dup_tok  <= bus.dup_tok | (|dup);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_commit_tracker.sv
// tb_pipe_commit_tracker: directed scenarios plus random epochs against a token-position reference model
module tb_pipe_commit_tracker;
    localparam int NP = 2, NS = 4, CW = 8, SAT = 132, EB = 50;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pipe_commit_tracker_if #(.NUM_PIPES(NP), .NUM_STAGES(NS), .CNT_W(CW)) bus();
    pipe_commit_tracker #(.NUM_PIPES(NP), .NUM_STAGES(NS), .CNT_W(CW), .CNT_SAT(SAT), .END_BOUND(EB))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0, errors = 0;
    logic             issue_v = 1'b0;
    logic [NP-1:0]    gate_v = '0, sel_v = '0;
    logic [NP*NS-1:0] stall_v = '0;
    // model: pos[p] = stage currently holding pipe p's token (0 = none)
    int        pos[NP];
    int        m_cnt;
    bit        m_start, m_started, m_ended, m_ended2, m_timeout;
    bit [NP-1:0] m_commit, m_lost;
    int cyc;
    int f_start, f_ended, f_e2, f_ended2, f_timeout, f_lost0;
    int f_commit[NP], cnt_at[NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_start"}, bus.start, 0);
        check({pfx, "_started"}, bus.started, 0);
        check({pfx, "_cnt"}, bus.cycle_cnt, 0);
        check({pfx, "_tok"}, bus.stage_tok, 0);
        check({pfx, "_commit"}, bus.commit, 0);
        check({pfx, "_ended"}, bus.ended, 0);
        check({pfx, "_ended2"}, bus.ended2, 0);
        check({pfx, "_timeout"}, bus.timeout, 0);
`ifdef PIPE_TOKEN_LOST_CHK_EN
        check({pfx, "_lost"}, bus.tok_lost, 0);
`endif
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            pos[p] = 0;
            f_commit[p] = -1;
            cnt_at[p] = -1;
        end
        m_cnt = 0;
        {m_start, m_started, m_ended, m_ended2, m_timeout} = '0;
        m_commit = '0;
        m_lost = '0;
        cyc = 0;
        {f_start, f_ended, f_e2, f_ended2, f_timeout, f_lost0} = {6{-32'sd1}};
    endtask

    task automatic release_rst();
        issue_v = 1'b0;
        bus.issue = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("rst");
        release_rst();
    endtask

    task automatic cycle();
        int cur[NP], nxt[NP];
        logic [NP*NS-1:0] etok;
        bit any, e2, hit, started_n;
        bit [NP-1:0] c;
        @(negedge clk);
        bus.issue = issue_v;
        bus.inj_gate = gate_v;
        bus.stall = stall_v;
        bus.end_sel = sel_v;
        #1;
        etok = '0;
        for (int p = 0; p < NP; p++) begin
            cur[p] = (m_start && gate_v[p]) ? 1 : pos[p];
            if (cur[p] > 0) etok[p*NS+cur[p]-1] = 1'b1;
        end
        any = |(m_commit & sel_v);
        hit = any && m_started;
        e2 = m_ended && hit && !m_ended2;
        check("start", bus.start, m_start);
        check("started", bus.started, m_started);
        check("cycle_cnt", bus.cycle_cnt, m_cnt);
        check("stage_tok", bus.stage_tok, etok);
        check("commit", bus.commit, m_commit);
        check("ended", bus.ended, m_ended);
        check("end2_pulse", bus.end2_pulse, e2);
        check("ended2", bus.ended2, m_ended2);
        check("timeout", bus.timeout, m_timeout);
`ifdef PIPE_TOKEN_LOST_CHK_EN
        check("tok_lost", bus.tok_lost, m_lost);
        check("dup_tok", bus.dup_tok, 0);
        if (f_lost0 < 0 && bus.tok_lost[0]) f_lost0 = cyc;
`endif
        if (f_start < 0 && bus.start) f_start = cyc;
        if (f_ended < 0 && bus.ended) f_ended = cyc;
        if (f_e2 < 0 && bus.end2_pulse) f_e2 = cyc;
        if (f_ended2 < 0 && bus.ended2) f_ended2 = cyc;
        if (f_timeout < 0 && bus.timeout) f_timeout = cyc;
        for (int p = 0; p < NP; p++)
            if (f_commit[p] < 0 && bus.commit[p]) begin
                f_commit[p] = cyc;
                cnt_at[p] = int'(bus.cycle_cnt);
            end
        for (int p = 0; p < NP; p++) begin
            nxt[p] = 0;
            c[p] = 1'b0;
            if (cur[p] > 0) begin
                if (stall_v[p*NS+cur[p]-1]) nxt[p] = (cur[p] >= 2) ? cur[p] : 0;
                else if (cur[p] == NS) c[p] = 1'b1;
                else if (stall_v[p*NS+cur[p]]) m_lost[p] = 1'b1;
                else nxt[p] = cur[p] + 1;
            end
        end
        m_timeout |= m_started && !m_ended && m_cnt > EB;
        m_ended2 |= e2;
        m_ended |= hit && m_cnt <= EB;
        if ((m_start || m_started) && m_cnt < SAT) m_cnt++;
        started_n = m_started | m_start;
        m_start = !(m_start || m_started) && issue_v;
        m_started = started_n;
        m_commit = c;
        pos = nxt;
        cyc++;
    endtask

    task automatic directed(input logic [NP-1:0] g, s, input int sbit, lo, hi, n);
        do_reset();
        gate_v = g;
        sel_v = s;
        issue_v = 1'b1;
        for (int i = 0; i < n; i++) begin
            stall_v = '0;
            if (sbit >= 0 && cyc >= lo && cyc <= hi) stall_v[sbit] = 1'b1;
            cycle();
        end
    endtask

    initial begin
        bus.issue = 1'b0;
        bus.inj_gate = '0;
        bus.stall = '0;
        bus.end_sel = '0;
        model_reset();
        directed(2'b11, 2'b10, -1, 0, 0, 12);
        check("t1_start_cyc", f_start, 1);
        check("t1_commit0_cyc", f_commit[0], 5);
        check("t1_commit1_cyc", f_commit[1], 5);
        check("t1_cnt_at_commit", cnt_at[1], 4);
        check("t1_ended_cyc", f_ended, 6);
        directed(2'b11, 2'b10, 6, 3, 5, 14);
        check("t2_commit1_cyc", f_commit[1], 8);
        check("t2_cnt_at_commit", cnt_at[1], 7);
        check("t2_ended_cyc", f_ended, 9);
        directed(2'b01, 2'b10, -1, 0, 0, 140);
        check("t3_commit1_never", f_commit[1], -1);
        check("t3_ended_never", f_ended, -1);
        check("t3_timeout_cyc", f_timeout, 53);
        check("t3_cnt_sat", bus.cycle_cnt, SAT);
        directed(2'b11, 2'b10, 2, 2, 2, 12);
        check("t4_commit0_never", f_commit[0], -1);
        check("t4_commit1_cyc", f_commit[1], 5);
`ifdef PIPE_TOKEN_LOST_CHK_EN
        check("t4_lost_cyc", f_lost0, 3);
`endif
        directed(2'b11, 2'b11, 6, 3, 4, 12);
        check("t5_ended_cyc", f_ended, 6);
        check("t5_end2_cyc", f_e2, 7);
        check("t5_ended2_cyc", f_ended2, 8);
        directed(2'b11, 2'b10, -1, 0, 0, 4);
        check("t6_tok_pre", bus.stage_tok, 8'b0100_0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        release_rst();
        issue_v = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("t6_restart_cyc", f_start, 1);
        check("t6_commit_cyc", f_commit[0], 5);
        for (int e = 0; e < 24; e++) begin
            int sp, len;
            do_reset();
            gate_v = NP'($urandom);
            sel_v = NP'($urandom);
            sp = $urandom_range(0, 3) * 10;
            len = (e % 4 == 0) ? 150 : $urandom_range(15, 60);
            for (int i = 0; i < len; i++) begin
                issue_v = ($urandom_range(0, 3) != 0);
                for (int b = 0; b < NP*NS; b++) stall_v[b] = ($urandom_range(0, 99) < sp);
                cycle();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
